fifo_uart_tx: RTL
=================

# fifo_uart_tx

Drains bytes from the read side of a first-word-fall-through FIFO and serializes each one onto an asynchronous UART line. It is the consumer end of the FIFO's read/empty handshake and sits between the FIFO and the board TX pin. Each byte goes out as a start bit, 8 data bits LSB first, an optional parity bit, and 1 or 2 stop bits.

## Interface

- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200). Must be >= 2.
- PARITY, 0: 0 = no parity bit, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits, 1 or 2.

- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- fifo_data  input  8  head-of-FIFO word. Valid combinationally whenever fifo_empty=0.
- fifo_empty  input  1  FIFO has no data.
- fifo_read  output  1  one-cycle pop strobe to the FIFO.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- Registers:
  - 8-bit shift register.
  - Baud counter, $clog2(CLKS_PER_BIT) bits.
  - 3-bit data-bit index.
  - 1-bit stop index.
  - Registered tx.
- fifo_read is combinational: (state==IDLE) && !fifo_empty && !rst. It is never asserted in any other state.
- IDLE:
  - tx=1.
  - When fifo_read=1, on the same edge: capture fifo_data into the shift register, clear the baud counter, set tx<=0, go to START.
- Bit period: the baud counter counts 0..CLKS_PER_BIT-1. "Bit end" is counter==CLKS_PER_BIT-1. At bit end the counter wraps to 0.
- START:
  - At bit end, tx<=shift[0], index<=0, go to DATA.
- DATA:
  - At bit end with index<7: shift right, index++, tx<=next bit.
  - At bit end with index==7:
    - If PARITY!=0: tx<=parity bit, go to PARITY.
    - Otherwise: tx<=1, go to STOP.
- Parity bit: even = XOR of the 8 captured data bits; odd = its inverse. Compute it from a copy of the captured byte, not from the shifted register.
- PARITY:
  - At bit end, tx<=1, go to STOP.
- STOP:
  - Lasts STOP_BITS bit periods with tx=1.
  - At the final bit end, go to IDLE.
- busy = (state != IDLE). This is a combinational decode of the registered state.
- No data is lost:
  - A byte is popped only when it will be transmitted.
  - fifo_empty is sampled only in IDLE.

## Timing

- Reset values: tx=1, busy=0, fifo_read=0, state=IDLE, all counters 0.
- Reset mid-frame:
  - Next edge: state=IDLE, tx=1.
  - The partially sent byte is discarded and not re-popped.
  - fifo_read stays 0 during every rst cycle.
- Frame length: (1 + 8 + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles of tx activity.
- Pop-to-line latency: tx falls on the edge that samples fifo_read=1. Pop and start bit begin in the same cycle.
- Back-to-back bytes:
  - After the final stop-bit period, exactly one IDLE cycle with tx=1 precedes the next pop.
  - Frame-start to frame-start period is therefore frame length + 1 cycles.
- FIFO becoming non-empty mid-frame: ignored until IDLE.
- Writes to the FIFO during transmission do not disturb the captured byte.
- A single-entry FIFO that empties on the pop: fifo_empty rising the cycle after the pop has no effect on the frame in progress.

## Test plan

- Reset state: CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1. Hold rst for 3 cycles with fifo_empty=0 -> tx=1, busy=0, fifo_read=0 throughout. First pop occurs the cycle after rst deasserts.
- Single byte: push 0xA5, then idle the FIFO -> one fifo_read pulse. tx sequence is 0, 1,0,1,0,0,1,0,1, 1, each level held 4 cycles (40 cycles). busy is high for exactly 40 cycles, then tx stays 1.
- Back-to-back: push 0x00, 0xFF, 0x3C -> three fifo_read pulses spaced exactly 41 cycles apart. Decoded bytes are 0x00, 0xFF, 0x3C in order. No pop while busy=1.
- Parity and stop bits: PARITY=1 (even) with byte 0x07 -> parity bit 1. PARITY=2 (odd) with byte 0x07 -> parity bit 0. STOP_BITS=2 -> high level after the parity bit lasts 8 cycles. Frame length is 48 cycles.
- Reset mid-frame: assert rst during DATA bit 3 of 0x55 -> tx=1 and busy=0 on the next edge. When the next queued byte 0x81 is sent, it is the complete frame for 0x81. 0x55 is not resent.
- Data arriving while busy: FIFO empty, push 0x12, then push 0x34 at cycle 10 of the first frame -> 0x34 is popped only after the first frame completes plus one IDLE cycle, and is transmitted intact.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a first-word-fall-through FIFO.
// Frames are: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] fifo_data,
   input  logic       fifo_empty,
   output logic       fifo_read,
   output logic       tx,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    byte_q, byte_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic          stop_q, stop_d;
   logic          tx_q, tx_d;
   logic          bit_end;
   logic          par_bit;

   assign bit_end   = (cnt_q == CNT_MAX);
   // Parity comes from the unshifted copy so it is stable through the frame.
   assign par_bit   = (^byte_q) ^ (PARITY == 2);
   assign fifo_read = (state_q == S_IDLE) && !fifo_empty && !rst;
   assign busy      = (state_q != S_IDLE);
   assign tx        = tx_q;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      idx_d   = idx_q;
      stop_d  = stop_q;
      tx_d    = tx_q;
      cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            tx_d  = 1'b1;
            if (fifo_read) begin
               shift_d = fifo_data;
               byte_d  = fifo_data;
               tx_d    = 1'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               idx_d   = 3'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (idx_q != 3'd7) begin
                  shift_d = shift_q >> 1;
                  idx_d   = idx_q + 3'd1;
                  tx_d    = shift_q[1];
               end else if (PARITY != 0) begin
                  tx_d    = par_bit;
                  state_d = S_PARITY;
               end else begin
                  tx_d    = 1'b1;
                  stop_d  = 1'b0;
                  state_d = S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               stop_d  = 1'b0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (stop_q == STOP_LAST) begin
                  stop_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         byte_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         stop_q  <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
         tx_q    <= tx_d;
      end
   end

endmodule
